// File: rtl/ones_frame_collector_pkg.sv
// Shared types and sizes for the ones-count front end.
// The frame width here must track the input width of the ones-count stage.
package ones_frame_collector_pkg;

  localparam int FRAME_W = 9;
  localparam int DROP_W  = 8;
  localparam int BCNT_W  = $clog2(FRAME_W);

  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } coll_state_t;

endpackage

// File: rtl/ones_frame_collector_frame_slot.sv
// One-entry valid/ready holding register for assembled frames.
// A load is accepted when the slot is empty or being drained this cycle; otherwise it is dropped.
module ones_frame_collector_frame_slot #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             accept,
  output logic             drop
);

  logic consume;

  always_comb begin
    consume = valid && ready;
    accept  = load && (!valid || ready);
    drop    = load && valid && !ready;
  end

  // A load in the same cycle as a transfer refills the slot, so back-to-back frames see no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (accept) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ones_frame_collector.sv
// Serial-to-parallel collector: assembles LSB-first WIDTH-bit frames and offers them
// through a one-entry slot, counting frames that arrive while the slot is still full.
module ones_frame_collector
  import ones_frame_collector_pkg::*;
#(
  parameter int WIDTH  = FRAME_W,
  parameter int DROP_W = ones_frame_collector_pkg::DROP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     sof,
  input  logic                     clr_ovr,
  output logic [WIDTH-1:0]         frame_out,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     overrun,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  coll_state_t      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             slot_accept;
  logic             slot_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // sof takes priority over a normal capture; with ser_valid it also captures the first bit.
  always_comb begin
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
    complete = 1'b0;
    pos      = (state_q == ST_IDLE) ? '0 : bcnt_q;
    word     = shift_q;
    if (sof) begin
      shift_d = '0;
      if (ser_valid) begin
        shift_d[0] = ser_in;
        bcnt_d     = CW'(1);
      end else begin
        bcnt_d     = '0;
      end
    end else if (ser_valid) begin
      word[pos] = ser_in;
      if (bcnt_q == LAST_POS) begin
        complete = 1'b1;
        shift_d  = '0;
        bcnt_d   = '0;
      end else begin
        shift_d  = word;
        bcnt_d   = bcnt_q + 1'b1;
      end
    end
    state_d = (bcnt_d == '0) ? ST_IDLE : ST_COLLECT;
  end

  ones_frame_collector_frame_slot #(
    .WIDTH(WIDTH)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_data (word),
    .ready     (frame_ready),
    .data      (frame_out),
    .valid     (frame_valid),
    .accept    (slot_accept),
    .drop      (slot_drop)
  );

  // A drop on the same edge as clr_ovr wins, leaving exactly one recorded drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (slot_drop) begin
      overrun <= 1'b1;
      if (clr_ovr)
        drop_cnt <= DROP_W'(1);
      else if (drop_cnt != DROP_MAX)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovr) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign bit_cnt = bcnt_q;

  logic unused_accept;
  assign unused_accept = slot_accept;

endmodule
